// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor with overflow, carry, zero and optional saturation
module addsub_serial #(
  parameter int WIDTH    = 16,
  parameter int DIGIT    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             v,
  output logic             c,
  output logic             z
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb, rs, res, sat_val;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   sum;
  logic             carry, last, ovf, clamp;
  always_comb begin
    sum = {1'b0, ra[cnt*DIGIT +: DIGIT]} + {1'b0, rb[cnt*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, carry};
    res = rs;
    res[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
  end
  // rb already holds the inverted operand for subtract, so sign comparison uses it directly
  assign last      = cnt == CW'(N - 1);
  assign ovf       = (ra[WIDTH-1] ~^ rb[WIDTH-1]) & (sum[DIGIT-1] ^ ra[WIDTH-1]);
  assign clamp     = SATURATE && ovf;
  assign sat_val   = {ra[WIDTH-1], {(WIDTH-1){~ra[WIDTH-1]}}};
  assign in_ready  = rst_n && state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      v     <= 1'b0;
      c     <= 1'b0;
      z     <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        ra    <= a;
        rb    <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      rs    <= res;
      carry <= sum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        s     <= clamp ? sat_val : res;
        v     <= ovf;
        c     <= sum[DIGIT];
        z     <= !clamp && res == '0;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: checks a wrapping DIGIT=4 instance and a saturating DIGIT=16 instance against an arithmetic model
module tb_addsub_serial;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready0, out_valid0, v0, c0, z0, in_ready1, out_valid1, v1, c1, z1;
  logic [15:0] s0, s1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .DIGIT(4), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid0), .out_ready(out_ready), .s(s0), .v(v0), .c(c0), .z(z0));
  addsub_serial #(.WIDTH(16), .DIGIT(16), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .v(v1), .c(c1), .z(z1));

  // returns {s, v, c, z} from signed integer arithmetic and an unsigned carry computation
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic sb, input logic sat);
    int sa;
    logic [16:0] u;
    logic ov;
    logic [15:0] r;
    sa = sb ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    u  = {1'b0, x} + {1'b0, sb ? ~y : y} + {16'd0, sb};
    ov = sa > 32767 || sa < -32768;
    r  = (ov && sat) ? (sa > 0 ? 16'h7fff : 16'h8000) : u[15:0];
    return {r, ov, u[16], r == 16'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // entered and left on a negedge with both instances idle
  task automatic run(input logic [15:0] x, input logic [15:0] y, input logic sb, input int hold);
    logic [18:0] e0, e1;
    int l0, l1;
    e0 = model(x, y, sb, 1'b0);
    e1 = model(x, y, sb, 1'b1);
    in_valid = 1'b1; a = x; b = y; sub = sb;
    chk("in_ready_idle", {in_ready0, in_ready1}, 2'b11);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    l0 = -1; l1 = -1;
    for (int t = 0; t <= 4; t++) begin
      if (l0 < 0 && out_valid0) l0 = t;
      if (l1 < 0 && out_valid1) l1 = t;
      if (t == 2) chk("in_ready_busy", in_ready0, 1'b0);
      if (t < 4) @(negedge clk);
    end
    chk("latency_d4", l0, 4);
    chk("latency_d16", l1, 1);
    chk("result_wrap", {s0, v0, c0, z0}, e0);
    chk("result_sat", {s1, v1, c1, z1}, e1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); out_ready = 1'b0;
      @(negedge clk);
      chk("hold_wrap", {out_valid0, in_ready0, s0, v0, c0, z0}, {2'b10, e0});
      chk("hold_sat", {out_valid1, in_ready1, s1, v1, c1, z1}, {2'b10, e1});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handshake", {out_valid0, in_ready0, out_valid1, in_ready1}, 4'b0101);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready0, out_valid0, s0, v0, c0, z0, in_ready1, out_valid1, s1, v1, c1, z1}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", {in_ready0, out_valid0, in_ready1, out_valid1}, 4'b1010);
    run(16'h1234, 16'h0001, 1'b0, 0);
    run(16'h0005, 16'h0005, 1'b1, 0);
    run(16'h7fff, 16'h0001, 1'b0, 0);
    run(16'h8000, 16'h0001, 1'b1, 0);
    run(16'h8000, 16'h8000, 1'b0, 1);
    run(16'h4321, 16'h1111, 1'b1, 5);
    run(16'h0000, 16'h0000, 1'b0, 0);
    run(16'hffff, 16'h7fff, 1'b1, 0);
    for (int k = 0; k < 25; k++)
      run(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    // abort: reset two cycles after accept
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {out_valid0, s0, v0, c0, z0, out_valid1, s1, v1, c1, z1}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_idle", {in_ready0, out_valid0, in_ready1, out_valid1}, 4'b1010);
    end
    run(16'h1234, 16'h0001, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
